// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with scoreboard: widths, index types, zero register.
package regfile_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_NREG = 32;
  localparam int REG_IDX_W    = $clog2(DEFAULT_NREG);
  localparam int ZERO_IDX     = 0;

  typedef logic [REG_IDX_W-1:0]    reg_idx_t;
  typedef logic [DEFAULT_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register, priority flush > issue-set > writeback-clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEFAULT_NREG,
  parameter int NWR  = 2,
  parameter int NISS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR*$clog2(NREG)-1:0]  wr_idx,
  input  logic [NISS-1:0]            iss_en,
  input  logic [NISS*$clog2(NREG)-1:0] iss_idx,
  input  logic                       flush,
  output logic [NREG-1:0]            busy_vec
);

  localparam int IDX_W = $clog2(NREG);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Register 0 is never pending, so its bit is constant zero.
  assign busy_next[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    logic set_hit;
    logic clr_hit;
    logic bit_next;

    always_comb begin
      set_hit = 1'b0;
      clr_hit = 1'b0;
      for (int s = 0; s < NISS; s++) begin
        if (iss_en[s] && (iss_idx[s*IDX_W +: IDX_W] == IDX_W'(gi))) set_hit = 1'b1;
      end
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == IDX_W'(gi))) clr_hit = 1'b1;
      end
      // A new producer issued alongside an older writeback keeps the register pending.
      if (flush)        bit_next = 1'b0;
      else if (set_hit) bit_next = 1'b1;
      else if (clr_hit) bit_next = 1'b0;
      else              bit_next = busy_reg[gi];
    end

    assign busy_next[gi] = bit_next;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads and mask rd_busy on a hit.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int NREG = DEFAULT_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int NISS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD*$clog2(NREG)-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]          rd_data,
  output logic [NRD-1:0]               rd_busy,
  input  logic [NWR-1:0]               wr_en,
  input  logic [NWR*$clog2(NREG)-1:0]  wr_idx,
  input  logic [NWR*XLEN-1:0]          wr_data,
  input  logic [NISS-1:0]              iss_en,
  input  logic [NISS*$clog2(NREG)-1:0] iss_idx,
  input  logic                         flush,
  output logic [NREG-1:0]              busy_vec
);

  localparam int IDX_W = $clog2(NREG);

  logic [XLEN-1:0] mem_reg [NREG];

  // Later ports are visited last, so the highest-numbered port wins on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_reg[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] != IDX_W'(ZERO_IDX)))
          mem_reg[wr_idx[w*IDX_W +: IDX_W]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .NISS (NISS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .iss_en   (iss_en),
    .iss_idx  (iss_idx),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [IDX_W-1:0] ridx;
    logic [XLEN-1:0]  data;
    logic             busy;

    assign ridx = rd_idx[gi*IDX_W +: IDX_W];

    always_comb begin
      data = (ridx == IDX_W'(ZERO_IDX)) ? '0 : mem_reg[ridx];
      busy = busy_vec[ridx];
`ifdef REGFILE_BYPASS_EN
      // Forwarded value is final, so the consumer need not wait on the scoreboard.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (ridx != IDX_W'(ZERO_IDX)) && (wr_idx[w*IDX_W +: IDX_W] == ridx)) begin
          data = wr_data[w*XLEN +: XLEN];
          busy = 1'b0;
        end
      end
`endif
    end

    assign rd_data[gi*XLEN +: XLEN] = data;
    assign rd_busy[gi]              = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a reference model of storage, bypass and scoreboard.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   rd_idx;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_idx;
  logic [127:0] wr_data;
  logic [0:0]   iss_en;
  logic [4:0]   iss_idx;
  logic         flush;
  logic [31:0]  busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_idx  (iss_idx),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural state as plain arrays
  logic [63:0] model_mem [32];
  logic [31:0] model_busy;
  bit          model_ok = 1'b0;

  function automatic bit write_hit(input logic [4:0] idx);
    write_hit = 1'b0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && idx != 0 && wr_idx[w*5 +: 5] == idx) write_hit = 1'b1;
  endfunction

  // Scan from the highest-priority port down; first hit is the forwarded value.
  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 64'd0;
    if (BYP) begin
      for (int w = 1; w >= 0; w--)
        if (wr_en[w] && wr_idx[w*5 +: 5] == idx) return wr_data[w*64 +: 64];
    end
    return model_mem[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) model_mem[r] = 64'd0;
      model_busy = 32'd0;
      model_ok   = 1'b1;
    end else if (model_ok) begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_idx[w*5 +: 5] != 0) model_mem[wr_idx[w*5 +: 5]] = wr_data[w*64 +: 64];
      if (flush) model_busy = 32'd0;
      else begin
        for (int w = 0; w < 2; w++)
          if (wr_en[w]) model_busy[wr_idx[w*5 +: 5]] = 1'b0;
        if (iss_en[0] && iss_idx != 0) model_busy[iss_idx] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !rst) begin
      for (int p = 0; p < 2; p++) begin
        logic [4:0] idx;
        logic       exp_b;
        idx   = rd_idx[p*5 +: 5];
        exp_b = (idx != 0) && model_busy[idx] && !(BYP && write_hit(idx));
        check($sformatf("model_rd_data%0d", p), rd_data[p*64 +: 64], model_read(idx));
        check($sformatf("model_rd_busy%0d", p), {63'd0, rd_busy[p]}, {63'd0, exp_b});
      end
      check("model_busy_vec", {32'd0, busy_vec}, {32'd0, model_busy});
    end
  end

  task automatic idle_inputs();
    wr_en = '0; wr_idx = '0; wr_data = '0;
    iss_en = '0; iss_idx = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] idx);
    rd_idx[p*5 +: 5] = idx;
  endtask

  task automatic set_wr(input int p, input logic [4:0] idx, input logic [63:0] d);
    wr_en[p] = 1'b1; wr_idx[p*5 +: 5] = idx; wr_data[p*64 +: 64] = d;
  endtask

  task automatic set_iss(input logic [4:0] idx);
    iss_en = 1'b1; iss_idx = idx;
  endtask

  // Commit current inputs on the next edge, then return inputs to idle.
  task automatic step(input string what);
    $display("txn %s rd_idx=%h wr_en=%b iss_en=%b flush=%b", what, rd_idx, wr_en, iss_en, flush);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  localparam logic [63:0] V3 = 64'hDEAD_BEEF_0000_0001;

  initial begin
    rst = 1'b1;
    rd_idx = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    @(negedge clk);
    check("reset_rd0", rd_data[63:0], 64'd0);
    check("reset_rd1", rd_data[127:64], 64'd0);
    check("reset_busy", {62'd0, rd_busy}, 64'd0);
    check("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    step("idle");

    // Single write with same-cycle read
    set_wr(0, 5'd3, V3); set_rd(0, 5'd3);
    @(negedge clk);
    check("wr_x3_same_cycle", rd_data[63:0], BYP ? V3 : 64'd0);
    step("wr x3");
    @(negedge clk);
    check("wr_x3_stored", rd_data[63:0], V3);
    step("rd x3");

    // Two ports to the same index, port 1 wins
    set_wr(0, 5'd7, 64'h11); set_wr(1, 5'd7, 64'h22); set_rd(1, 5'd7);
    @(negedge clk);
    check("wr_x7_same_cycle", rd_data[127:64], BYP ? 64'h22 : 64'd0);
    step("wr x7 both ports");
    @(negedge clk);
    check("wr_x7_stored", rd_data[127:64], 64'h22);
    step("rd x7");

    // Issue then delayed writeback
    set_iss(5'd9); set_rd(0, 5'd9);
    @(negedge clk);
    check("iss_x9_same_cycle_busy", {63'd0, rd_busy[0]}, 64'd0);
    step("iss x9");
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("x9_busy_cycle%0d", c), {63'd0, rd_busy[0]}, 64'd1);
      step("idle");
    end
    set_wr(1, 5'd9, 64'h5);
    @(negedge clk);
    check("x9_wb_cycle_busy", {63'd0, rd_busy[0]}, BYP ? 64'd0 : 64'd1);
    step("wb x9");
    @(negedge clk);
    check("x9_cleared", {63'd0, busy_vec[9]}, 64'd0);
    check("x9_value", rd_data[63:0], 64'h5);

    // Issue and writeback on the same cycle: set wins
    set_iss(5'd4); set_wr(0, 5'd4, 64'h8); set_rd(0, 5'd4);
    step("iss+wb x4");
    @(negedge clk);
    check("x4_busy_set_wins", {63'd0, busy_vec[4]}, 64'd1);
    check("x4_value", rd_data[63:0], 64'h8);

    // Flush beats a same-cycle issue and leaves data alone
    set_iss(5'd10); step("iss x10");
    set_iss(5'd11); step("iss x11");
    set_iss(5'd12); step("iss x12");
    @(negedge clk);
    check("pre_flush_busy", {32'd0, busy_vec}, 64'h1C10);
    set_iss(5'd13); flush = 1'b1; set_rd(0, 5'd3);
    step("flush+iss x13");
    @(negedge clk);
    check("post_flush_busy", {32'd0, busy_vec}, 64'd0);
    check("post_flush_x3", rd_data[63:0], V3);
    check("post_flush_x7", rd_data[127:64], 64'h22);

    // Register zero ignores writes and issues
    set_wr(1, 5'd0, 64'hFF); set_iss(5'd0); set_rd(0, 5'd0);
    @(negedge clk);
    check("x0_same_cycle", rd_data[63:0], 64'd0);
    step("wr+iss x0");
    @(negedge clk);
    check("x0_read", rd_data[63:0], 64'd0);
    check("x0_busy_vec", {32'd0, busy_vec}, 64'd0);

    // Reset mid-operation overrides write/issue
    set_iss(5'd20); set_wr(0, 5'd3, 64'h1234); rst = 1'b1; set_rd(0, 5'd3);
    step("reset with activity");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_x3", rd_data[63:0], 64'd0);
    check("midrst_busy_vec", {32'd0, busy_vec}, 64'd0);
    step("idle");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the multi-issue pipeline. Provides NRD read ports and NWR write ports, with write-to-read bypass.
- Contains an integrated busy-bit scoreboard. Issue marks a destination as pending; writeback clears it.
- Sits between decode/issue (operand read, hazard check) and the writeback stage. Replaces the single-write, two-read register file.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; a higher index has higher priority.
- NISS, 1, number of issue (busy-set) ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_idx  in  NRD*$clog2(NREG)  packed read indices; port i is slice i.
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  read register pending (not yet written back).
- wr_en  in  NWR  per-port write enable.
- wr_idx  in  NWR*$clog2(NREG)  write indices.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  NISS  issue valid; marks the destination busy.
- iss_idx  in  NISS*$clog2(NREG)  issued destination indices.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  NREG  full scoreboard, for debug/trace.

Behaviour:
- Reset: every register is 0 and every busy bit is 0. rd_data is 0 for all ports; rd_busy = 0; busy_vec = 0.
- Index 0: reads return 0 and are never busy. Writes and issues to index 0 are ignored.
- Storage write: on each rising edge, for each port w with wr_en[w] and wr_idx != 0, reg[wr_idx] <= wr_data.
  - Same index on several ports: the highest-numbered port wins.
  - Write latency into storage: 1 cycle.
- Read: combinational from rd_idx, 0 cycles.
  - Bypass: if any write port hits rd_idx this cycle (wr_en, idx != 0), rd_data is that port's wr_data. Highest-priority port wins, matching storage.
  - Otherwise rd_data is the stored value.
- Scoreboard, next-state per register r != 0:
  - busy[r] <= 0 on flush.
  - Else busy[r] <= 1 if any iss_en hits r.
  - Else busy[r] <= 0 if any wr_en hits r.
  - Else hold.
- Issue and writeback to the same register in the same cycle: set wins, because the new producer supersedes.
- flush has priority over issue in the same cycle.
- flush does not alter register contents.
- rd_busy[i]:
  - busy[rd_idx[i]], masked to 0 if a write port hits rd_idx[i] in the same cycle (bypassed value is final).
  - An issue in the same cycle does not affect rd_busy until the next cycle.
- Reset asserted mid-operation: takes effect at the next edge regardless of wr_en, iss_en or flush.

Optional Feature:
- REGFILE_BYPASS_EN, when defined:
  - write-to-read bypass as above;
  - same-cycle write masks rd_busy.
- When undefined:
  - rd_data is the stored value only, so a write is visible to reads the cycle after;
  - rd_busy is busy[rd_idx] unmasked;
  - scoreboard update rules are unchanged.

Decomposition:
- Shared package regfile_pkg:
  - REG_IDX_W = $clog2(NREG);
  - ZERO_IDX = 0;
  - default XLEN/NREG;
  - typedef reg_idx_t [REG_IDX_W-1:0];
  - typedef xlen_t [XLEN-1:0].
- One sub-module, regfile_scoreboard: holds the busy vector with set/clear/flush priority. Parametrised on NREG, NWR, NISS.
- Data storage and bypass muxing stay in regfile_sb.

Test Plan:
- Reset, then read x5 on port 0 and x31 on port 1 -> rd_data 0 and 0; rd_busy 00; busy_vec all 0.
- Write x3 = 0xDEAD_BEEF_0000_0001 on wr port 0; read x3 in the same cycle -> bypass gives 0xDEAD_BEEF_0000_0001. Next cycle with wr_en = 0 -> same value from storage. With REGFILE_BYPASS_EN undefined, the same-cycle read returns 0.
- wr port 0 x7 = 0x11 and port 1 x7 = 0x22 in the same cycle -> same-cycle read = 0x22; next cycle stored value = 0x22.
- Issue x9, then after 3 idle cycles write back x9 = 0x5 -> rd_busy for x9 is 1 during cycles 1..3. With bypass, 0 in the writeback cycle; busy_vec[9] = 0 after the edge.
- Issue x4 and write back x4 = 0x8 in the same cycle -> busy_vec[4] = 1 next cycle; stored x4 = 0x8.
- Issue x10, x11, x12, then flush together with an issue of x13 -> all busy bits 0 next cycle; register values unchanged.
- Write and issue to x0 -> reads 0; busy_vec[0] stays 0.
